counter_sequencer_ctrl: RTL and testbench

//   Run-control sequencer for a synchronous up-counter datapath. Latches a terminal

---
 rtl/counter_sequencer_ctrl_pkg.sv | 13 +
 rtl/counter_sequencer_ctrl_core.sv | 41 ++++
 rtl/counter_sequencer_ctrl.sv | 123 ++++++++++++
 tb/tb_counter_sequencer_ctrl.sv | 139 +++++++++++++
 4 files changed

// File: rtl/counter_sequencer_ctrl_pkg.sv
// Shared types and defaults for the counter sequencer.
package counter_sequencer_ctrl_pkg;

   localparam int unsigned CSEQ_WIDTH_DEFAULT = 4;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_RUN    = 2'd1,
      ST_PAUSED = 2'd2,
      ST_DONE   = 2'd3
   } cseq_state_e;

endpackage : counter_sequencer_ctrl_pkg

// File: rtl/counter_sequencer_ctrl_core.sv
// Counter datapath: WIDTH-bit up-counter with synchronous clear/enable and terminal compare.
module counter_seq_core
   import counter_sequencer_ctrl_pkg::*;
#(
   parameter int unsigned WIDTH = CSEQ_WIDTH_DEFAULT
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             clr,
   input  logic             en,
   input  logic [WIDTH-1:0] term,
   output logic [WIDTH-1:0] count,
   output logic             at_term
);

   logic [WIDTH-1:0] count_q;
   logic [WIDTH-1:0] count_d;

   // Next count: clear wins over enable, otherwise hold.
   always_comb begin
      count_d = count_q;
      if (clr) begin
         count_d = '0;
      end else if (en) begin
         count_d = count_q + 1'b1;
      end
   end

   // Counter register with synchronous reset.
   always_ff @(posedge clk) begin
      if (reset) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   assign count   = count_q;
   assign at_term = (count_q == term);

endmodule : counter_seq_core

// File: rtl/counter_sequencer_ctrl.sv
// Run-control sequencer: start/stop/pause FSM driving an up-counter to a latched
// terminal value, with one-shot (DONE) or auto-reload operation.
module counter_sequencer_ctrl
   import counter_sequencer_ctrl_pkg::*;
#(
   parameter int unsigned WIDTH = CSEQ_WIDTH_DEFAULT
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic             stop,
   input  logic             pause,
   input  logic             auto_reload,
   input  logic [WIDTH-1:0] load_val,
   output logic [WIDTH-1:0] count,
   output logic             busy,
   output logic             tc,
   output logic             done
);

   cseq_state_e      state_q;
   logic [WIDTH-1:0] term_q;
   logic             mode_q;
   logic             tc_q;
   logic             done_q;
   logic             busy_q;

   logic             cnt_clr;
   logic             cnt_en;
   logic             at_term;

   counter_seq_core #(
      .WIDTH (WIDTH)
   ) u_core (
      .clk     (clk),
      .reset   (reset),
      .clr     (cnt_clr),
      .en      (cnt_en),
      .term    (term_q),
      .count   (count),
      .at_term (at_term)
   );

   // Counter control decode; mirrors the FSM's priority (stop > start > pause).
   always_comb begin
      cnt_clr = 1'b0;
      cnt_en  = 1'b0;
      if (stop) begin
         cnt_clr = 1'b1;
      end else begin
         unique case (state_q)
            ST_IDLE, ST_DONE: cnt_clr = start;
            ST_RUN: begin
               if (!pause) begin
                  if (at_term) begin
                     cnt_clr = mode_q;
                  end else begin
                     cnt_en = 1'b1;
                  end
               end
            end
            default: ;
         endcase
      end
   end

   // Sequencer FSM with registered busy/tc/done and latched terminal/mode.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= ST_IDLE;
         term_q  <= '0;
         mode_q  <= 1'b0;
         tc_q    <= 1'b0;
         done_q  <= 1'b0;
         busy_q  <= 1'b0;
      end else if (stop) begin
         state_q <= ST_IDLE;
         tc_q    <= 1'b0;
         done_q  <= 1'b0;
         busy_q  <= 1'b0;
      end else begin
         unique case (state_q)
            ST_IDLE, ST_DONE: begin
               tc_q <= 1'b0;
               if (start) begin
                  term_q  <= load_val;
                  mode_q  <= auto_reload;
                  state_q <= ST_RUN;
                  busy_q  <= 1'b1;
                  done_q  <= 1'b0;
               end
            end
            ST_RUN: begin
               if (pause) begin
                  state_q <= ST_PAUSED;
                  tc_q    <= 1'b0;
               end else if (at_term) begin
                  tc_q <= 1'b1;
                  if (!mode_q) begin
                     state_q <= ST_DONE;
                     done_q  <= 1'b1;
                     busy_q  <= 1'b0;
                  end
               end else begin
                  tc_q <= 1'b0;
               end
            end
            ST_PAUSED: begin
               tc_q <= 1'b0;
               if (!pause) begin
                  state_q <= ST_RUN;
               end
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

   assign busy = busy_q;
   assign tc   = tc_q;
   assign done = done_q;

endmodule : counter_sequencer_ctrl

// File: tb/tb_counter_sequencer_ctrl.sv
// Directed bench for counter_sequencer_ctrl with an expected-output queue.
module tb_counter_sequencer_ctrl;

   localparam int unsigned W = 4;

   logic         clk = 1'b0;
   logic         reset, start, stop, pause, auto_reload;
   logic [W-1:0] load_val;
   logic [W-1:0] count;
   logic         busy, tc, done;

   typedef struct {
      logic [W+2:0] exp;
      string        tag;
   } exp_t;

   exp_t exp_q[$];
   int   checks = 0;
   int   errors = 0;

   counter_sequencer_ctrl #(.WIDTH(W)) dut (
      .clk         (clk),
      .reset       (reset),
      .start       (start),
      .stop        (stop),
      .pause       (pause),
      .auto_reload (auto_reload),
      .load_val    (load_val),
      .count       (count),
      .busy        (busy),
      .tc          (tc),
      .done        (done)
   );

   always #5 clk = ~clk;

   // One clock: drive inputs at negedge, push expectation, compare 1 time unit after posedge.
   task automatic step(input logic r, input logic st, input logic sp, input logic pa,
                       input logic ar, input logic [W-1:0] lv,
                       input logic [W-1:0] ec, input logic eb, input logic et,
                       input logic ed, input string tag);
      exp_t e;
      logic [W+2:0] obs;
      @(negedge clk);
      reset = r; start = st; stop = sp; pause = pa; auto_reload = ar; load_val = lv;
      e.exp = {ec, eb, et, ed};
      e.tag = tag;
      exp_q.push_back(e);
      @(posedge clk);
      #1;
      e   = exp_q.pop_front();
      obs = {count, busy, tc, done};
      checks++;
      assert (obs === e.exp) else begin
         errors++;
         $error("FAIL %s observed count=%0d busy=%b tc=%b done=%b expected count=%0d busy=%b tc=%b done=%b",
                e.tag, obs[W+2:3], obs[2], obs[1], obs[0], e.exp[W+2:3], e.exp[2], e.exp[1], e.exp[0]);
      end
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog expired observed running expected finished");
      $fatal(1, "timeout");
   end

   initial begin
      reset = 1'b1; start = 1'b0; stop = 1'b0; pause = 1'b0; auto_reload = 1'b0; load_val = '0;

      // 1: reset with start held
      step(1, 1, 0, 0, 0, 4'd3, 4'd0, 0, 0, 0, "rst0");
      step(1, 1, 0, 0, 0, 4'd3, 4'd0, 0, 0, 0, "rst1");
      step(0, 0, 0, 0, 0, 4'd3, 4'd0, 0, 0, 0, "idle");

      // 2: one-shot, terminal 3
      step(0, 1, 0, 0, 0, 4'd3, 4'd0, 1, 0, 0, "os_start");
      step(0, 0, 0, 0, 0, 4'd0, 4'd1, 1, 0, 0, "os_c1");
      step(0, 0, 0, 0, 0, 4'd0, 4'd2, 1, 0, 0, "os_c2");
      step(0, 0, 0, 0, 0, 4'd0, 4'd3, 1, 0, 0, "os_c3");
      step(0, 0, 0, 0, 0, 4'd0, 4'd3, 0, 1, 1, "os_tc");
      step(0, 0, 0, 0, 0, 4'd0, 4'd3, 0, 0, 1, "os_hold1");
      step(0, 0, 0, 0, 0, 4'd0, 4'd3, 0, 0, 1, "os_hold2");
      step(0, 0, 1, 0, 0, 4'd0, 4'd0, 0, 0, 0, "os_stop");

      // 3: auto-reload, terminal 2 -> period 3
      step(0, 1, 0, 0, 1, 4'd2, 4'd0, 1, 0, 0, "ar_start");
      for (int i = 1; i <= 12; i++) begin
         logic [W-1:0] c;
         c = W'(i % 3);
         step(0, 0, 0, 0, 0, 4'd9, c, 1, (i % 3 == 0), 0, $sformatf("ar_%0d", i));
      end
      step(0, 0, 1, 0, 0, 4'd0, 4'd0, 0, 0, 0, "ar_stop");

      // 4: pause at count 2, start during pause ignored
      step(0, 1, 0, 0, 0, 4'd5, 4'd0, 1, 0, 0, "pz_start");
      step(0, 0, 0, 0, 0, 4'd0, 4'd1, 1, 0, 0, "pz_c1");
      step(0, 0, 0, 0, 0, 4'd0, 4'd2, 1, 0, 0, "pz_c2");
      step(0, 0, 0, 1, 0, 4'd0, 4'd2, 1, 0, 0, "pz_p1");
      step(0, 1, 0, 1, 1, 4'd1, 4'd2, 1, 0, 0, "pz_p2_start");
      step(0, 0, 0, 1, 0, 4'd0, 4'd2, 1, 0, 0, "pz_p3");
      step(0, 0, 0, 0, 0, 4'd0, 4'd2, 1, 0, 0, "pz_release");
      step(0, 0, 0, 0, 0, 4'd0, 4'd3, 1, 0, 0, "pz_c3");
      step(0, 0, 0, 0, 0, 4'd0, 4'd4, 1, 0, 0, "pz_c4");
      step(0, 0, 0, 0, 0, 4'd0, 4'd5, 1, 0, 0, "pz_c5");
      step(0, 0, 0, 0, 0, 4'd0, 4'd5, 0, 1, 1, "pz_tc");
      step(0, 0, 1, 0, 0, 4'd0, 4'd0, 0, 0, 0, "pz_stop");

      // 5: stop+start together, then load_val=0 one-shot, then restart from DONE
      step(0, 1, 0, 0, 0, 4'd3, 4'd0, 1, 0, 0, "ss_start");
      step(0, 0, 0, 0, 0, 4'd0, 4'd1, 1, 0, 0, "ss_c1");
      step(0, 1, 1, 0, 0, 4'd3, 4'd0, 0, 0, 0, "ss_both");
      step(0, 1, 0, 0, 0, 4'd0, 4'd0, 1, 0, 0, "z_start");
      step(0, 0, 0, 0, 0, 4'd0, 4'd0, 0, 1, 1, "z_done");
      step(0, 0, 0, 0, 0, 4'd0, 4'd0, 0, 0, 1, "z_hold");
      step(0, 1, 0, 0, 0, 4'd1, 4'd0, 1, 0, 0, "rd_start");
      step(0, 0, 0, 0, 0, 4'd0, 4'd1, 1, 0, 0, "rd_c1");
      step(0, 0, 0, 0, 0, 4'd0, 4'd1, 0, 1, 1, "rd_tc");
      step(0, 0, 1, 0, 0, 4'd0, 4'd0, 0, 0, 0, "rd_stop");

      // 5b: load_val=0 auto-reload -> tc every cycle
      step(0, 1, 0, 0, 1, 4'd0, 4'd0, 1, 0, 0, "za_start");
      step(0, 0, 0, 0, 0, 4'd0, 4'd0, 1, 1, 0, "za_tc1");
      step(0, 0, 0, 0, 0, 4'd0, 4'd0, 1, 1, 0, "za_tc2");
      step(0, 0, 1, 0, 0, 4'd0, 4'd0, 0, 0, 0, "za_stop");

      // 6: reset mid auto-reload run
      step(0, 1, 0, 0, 1, 4'd3, 4'd0, 1, 0, 0, "rm_start");
      step(0, 0, 0, 0, 0, 4'd0, 4'd1, 1, 0, 0, "rm_c1");
      step(0, 0, 0, 0, 0, 4'd0, 4'd2, 1, 0, 0, "rm_c2");
      step(0, 0, 0, 0, 0, 4'd0, 4'd3, 1, 0, 0, "rm_c3");
      step(1, 0, 0, 0, 0, 4'd0, 4'd0, 0, 0, 0, "rm_reset");
      step(0, 0, 0, 0, 0, 4'd0, 4'd0, 0, 0, 0, "rm_idle1");
      step(0, 0, 0, 1, 0, 4'd0, 4'd0, 0, 0, 0, "rm_idle2");

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule : tb_counter_sequencer_ctrl
